// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory request/valid bus between fetch stage and imem
interface fetch_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencing and instruction fetch for the 16-bit MIPS core
// Optional retired-instruction counter enabled by defining FETCH_RETIRE_CNT_EN.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master imem,
    output logic [15:0]       instr,
    output logic [2:0]        opcode,
    output logic [3:0]        function_extend,
    output logic              instr_valid,
    output logic [15:0]       pc,
    output logic [15:0]       link_pc,
    input  logic [1:0]        PC_sel,
    input  logic              HLT_RST,
    input  logic [15:0]       jr_target,
    input  logic              resume,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_JR     = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;
    localparam logic [1:0] SEL_JUMP   = 2'b11;

    logic [1:0]  state;
    logic [15:0] pc_plus1;
    logic [15:0] imm_sext;
    logic [15:0] branch_target;
    logic [15:0] jump_target;
    logic [15:0] pc_next;

    assign pc_plus1      = pc + 16'd1;
    assign imm_sext      = {{9{instr[6]}}, instr[6:0]};
    assign branch_target = pc_plus1 + imm_sext;
    // Jumps stay inside the 8K-word region of the following instruction.
    assign jump_target   = {pc_plus1[15:13], instr[12:0]};

    always_comb begin
        pc_next = pc_plus1;
        if (HLT_RST) begin
            case (PC_sel)
                SEL_SEQ:    pc_next = pc_plus1;
                SEL_JR:     pc_next = jr_target;
                SEL_BRANCH: pc_next = branch_target;
                SEL_JUMP:   pc_next = jump_target;
                default:    pc_next = pc_plus1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            instr <= 16'h0000;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        instr <= imem.imem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    pc    <= pc_next;
                    state <= HLT_RST ? S_FETCH : S_HALT;
                end
                S_HALT: begin
                    if (resume) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Request is suppressed while reset is held even though the state is already FETCH.
    assign imem.imem_req    = (state == S_FETCH) && !rst;
    assign imem.imem_addr   = pc;
    assign instr_valid      = (state == S_EXEC);
    assign halted           = (state == S_HALT);
    assign opcode           = instr[15:13];
    assign function_extend  = instr[3:0];
    assign link_pc          = pc_plus1;

`ifdef FETCH_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_EXEC) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign retired_cnt = cnt;
`else
    assign retired_cnt = '0;
`endif

endmodule
